conv_layer_input_ctrl: RTL and testbench

Upstream control stage of the convolution layer input path. Accepts a raster pixel stream over a valid/ready handshake. Drives the 3-row line buffer's `data_in`, `col_index`, `row_index`, `preload_cycle` and `current_state` so the buffer preloads three rows, exposes each 3-row window to the kernel, then loads one new row per output row until the 8×8 frame is consumed.

---
 rtl/conv_layer_input_ctrl_if.sv | 21 ++
 rtl/conv_layer_input_ctrl.sv | 148 ++++++++++++++
 tb/tb_conv_layer_input_ctrl.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_layer_input_ctrl_if.sv
// Pixel stream handshake between the raster source and the input controller.
// The master drives valid/data; the slave returns ready.
interface conv_layer_input_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );
endinterface

// File: rtl/conv_layer_input_ctrl.sv
// Input-side controller for the 3-row line buffer: preloads three rows, exposes each window,
// then streams one new row per output row until the frame is consumed.
module conv_layer_input_ctrl #(
  parameter int unsigned IMAGE_SIZE       = 8,
  parameter int unsigned KERNEL_SIZE      = 3,
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned BUFFER_COL_WIDTH = 4,
  parameter int unsigned BUFFER_ROW_WIDTH = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        start_i,
  conv_layer_input_ctrl_if.slave      pix_if,
  output logic [DATA_WIDTH-1:0]       data_in_o,
  output logic [BUFFER_COL_WIDTH-1:0] col_index_o,
  output logic [BUFFER_ROW_WIDTH-1:0] row_index_o,
  output logic [BUFFER_ROW_WIDTH-1:0] preload_cycle_o,
  output logic [2:0]                  current_state_o,
  output logic                        win_valid_o,
  output logic [2:0]                  out_row_o,
  output logic                        busy_o,
  output logic                        done_o
);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StInit    = 3'd1,
    StPreload = 3'd2,
    StShift   = 3'd3,
    StBias    = 3'd4,
    StLoad    = 3'd5
  } state_e;

  localparam logic [BUFFER_COL_WIDTH-1:0] ColEnd      = BUFFER_COL_WIDTH'(IMAGE_SIZE);
  localparam logic [BUFFER_COL_WIDTH-1:0] LastCol     = BUFFER_COL_WIDTH'(IMAGE_SIZE - 1);
  localparam logic [BUFFER_ROW_WIDTH-1:0] RowNone     = BUFFER_ROW_WIDTH'(KERNEL_SIZE);
  localparam logic [BUFFER_ROW_WIDTH-1:0] LastRow     = BUFFER_ROW_WIDTH'(KERNEL_SIZE - 1);
  localparam logic [BUFFER_ROW_WIDTH-1:0] PreloadLast = BUFFER_ROW_WIDTH'(KERNEL_SIZE);
  localparam logic [BUFFER_ROW_WIDTH-1:0] PreloadOne  = BUFFER_ROW_WIDTH'(1);
  localparam logic [2:0]                  LastOutRow  = 3'(IMAGE_SIZE - KERNEL_SIZE);

  state_e                      state_q;
  logic [BUFFER_COL_WIDTH-1:0] col_q;
  logic [BUFFER_ROW_WIDTH-1:0] row_q;
  logic [BUFFER_ROW_WIDTH-1:0] pc_q;
  logic [2:0]                  out_row_q;
  logic                        win_q;
  logic                        done_q;

  logic feed;
  logic hs;

  always_comb begin
    feed = ((state_q == StPreload) || (state_q == StLoad)) && (col_q < ColEnd);
    hs   = feed && pix_if.in_valid;
    pix_if.in_ready = feed;
    // Present IDLE while stalled so the buffer does not re-shift on every wait cycle.
    if (feed && !pix_if.in_valid) begin
      current_state_o = StIdle;
    end else begin
      current_state_o = state_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      col_q     <= '0;
      row_q     <= RowNone;
      pc_q      <= PreloadOne;
      out_row_q <= '0;
      win_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            state_q <= StInit;
          end
        end
        StInit: begin
          state_q   <= StPreload;
          col_q     <= '0;
          pc_q      <= PreloadOne;
          out_row_q <= '0;
        end
        StPreload: begin
          if (col_q < ColEnd) begin
            if (hs) begin
              col_q <= col_q + 1'b1;
            end
          end else if (pc_q < PreloadLast) begin
            // Column 8 is the internal shift cycle between preload rows.
            pc_q  <= pc_q + 1'b1;
            col_q <= '0;
          end else begin
            state_q <= StShift;
            row_q   <= '0;
            win_q   <= 1'b1;
          end
        end
        StShift: begin
          if (row_q == LastRow) begin
            state_q <= StBias;
            row_q   <= RowNone;
            win_q   <= 1'b0;
          end else begin
            row_q <= row_q + 1'b1;
          end
        end
        StBias: begin
          if (out_row_q < LastOutRow) begin
            out_row_q <= out_row_q + 1'b1;
            col_q     <= '0;
            state_q   <= StLoad;
          end else begin
            state_q <= StIdle;
            done_q  <= 1'b1;
          end
        end
        StLoad: begin
          if (hs) begin
            col_q <= col_q + 1'b1;
            if (col_q == LastCol) begin
              state_q <= StShift;
              row_q   <= '0;
              win_q   <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign data_in_o       = pix_if.in_data;
  assign col_index_o     = col_q;
  assign row_index_o     = row_q;
  assign preload_cycle_o = pc_q;
  assign win_valid_o     = win_q;
  assign out_row_o       = out_row_q;
  assign busy_o          = (state_q != StIdle);
  assign done_o          = done_q;

endmodule

// File: tb/tb_conv_layer_input_ctrl.sv
// Directed bench for conv_layer_input_ctrl: per-cycle traces of each frame are recorded and
// checked against hand-computed cycle numbers.
module tb_conv_layer_input_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;

  logic [31:0] data_in;
  logic [3:0]  col_index;
  logic [1:0]  row_index;
  logic [1:0]  preload_cycle;
  logic [2:0]  current_state;
  logic        win_valid;
  logic [2:0]  out_row;
  logic        busy;
  logic        done;

  conv_layer_input_ctrl_if #(.DATA_WIDTH(32)) pix_if ();
  assign pix_if.in_valid = in_valid;
  assign pix_if.in_data  = in_data;

  conv_layer_input_ctrl dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .start_i         (start),
    .pix_if          (pix_if),
    .data_in_o       (data_in),
    .col_index_o     (col_index),
    .row_index_o     (row_index),
    .preload_cycle_o (preload_cycle),
    .current_state_o (current_state),
    .win_valid_o     (win_valid),
    .out_row_o       (out_row),
    .busy_o          (busy),
    .done_o          (done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int dat_bad = 0;

  int st_tr  [200];
  int rdy_tr [200];
  int col_tr [200];
  int row_tr [200];
  int pc_tr  [200];
  int or_tr  [200];
  int win_tr [200];
  int busy_tr[200];
  int pix_tr [200];
  int st_sv  [200];
  int col_sv [200];
  int row_sv [200];

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Caller leaves start=1 before the edge that launches the frame; cycle 0 is INIT.
  task automatic run_frame(input int bub_at, input int bub_len, input int start_at,
                           input int abort_at, input bit restart,
                           output int done_cyc, output int npix, output int nwin,
                           output int ndone, output int nshift0);
    int c;
    int post;
    done_cyc = -1;
    npix = 0;
    nwin = 0;
    ndone = 0;
    nshift0 = 0;
    post = 0;
    c = 0;
    while (c < 200) begin
      @(posedge clk);
      #1;
      start    = (c == start_at);
      in_valid = !((c >= bub_at) && (c < bub_at + bub_len));
      in_data  = npix;
      #1;
      st_tr[c]   = int'(current_state);
      rdy_tr[c]  = int'(pix_if.in_ready);
      col_tr[c]  = int'(col_index);
      row_tr[c]  = int'(row_index);
      pc_tr[c]   = int'(preload_cycle);
      or_tr[c]   = int'(out_row);
      win_tr[c]  = int'(win_valid);
      busy_tr[c] = int'(busy);
      pix_tr[c]  = npix;
      if (data_in !== in_data) dat_bad++;
      if (win_valid) nwin++;
      if (current_state == 3'd5 && col_index == 4'd0) nshift0++;
      if (done) begin
        ndone++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (in_valid && pix_if.in_ready) npix++;
      if (c == abort_at) return;
      if (done_cyc >= 0) begin
        if (restart) begin
          start = 1'b1;
          return;
        end
        post++;
        if (post > 3) return;
      end
      c++;
    end
  endtask

  int dc, np, nw, nd, ns, diffs, ndone_r, nbusy_r;

  initial begin
    // Reset values, checked asynchronously before any clock edge.
    #2 rst = 1'b1;
    #1;
    chk("rst_state", int'(current_state), 0);
    chk("rst_col", int'(col_index), 0);
    chk("rst_row", int'(row_index), 3);
    chk("rst_pc", int'(preload_cycle), 1);
    chk("rst_outrow", int'(out_row), 0);
    chk("rst_ready", int'(pix_if.in_ready), 0);
    chk("rst_win", int'(win_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Full frame, continuous valid.
    start = 1'b1;
    run_frame(-1, 0, -1, -1, 1'b0, dc, np, nw, nd, ns);
    chk("f1_done_cyc", dc, 92);
    chk("f1_pixels", np, 64);
    chk("f1_win_cycles", nw, 18);
    chk("f1_done_count", nd, 1);
    chk("f1_load_shifts", ns, 5);
    chk("f1_data_in", dat_bad, 0);
    chk("f1_c0_init", st_tr[0], 1);
    chk("f1_c0_busy", busy_tr[0], 1);
    chk("f1_c0_ready", rdy_tr[0], 0);
    chk("f1_c1_preload", st_tr[1], 2);
    chk("f1_c1_ready", rdy_tr[1], 1);
    chk("f1_c8_col", col_tr[8], 7);
    chk("f1_c9_col", col_tr[9], 8);
    chk("f1_c9_ready", rdy_tr[9], 0);
    chk("f1_c9_pc", pc_tr[9], 1);
    chk("f1_c10_col", col_tr[10], 0);
    chk("f1_c18_ready", rdy_tr[18], 0);
    chk("f1_c18_pc", pc_tr[18], 2);
    chk("f1_c27_ready", rdy_tr[27], 0);
    chk("f1_c27_pc", pc_tr[27], 3);
    chk("f1_c27_st", st_tr[27], 2);
    chk("f1_pix_at_c9", pix_tr[10], 8);
    chk("f1_pix_at_shift", pix_tr[28], 24);
    chk("f1_c27_row", row_tr[27], 3);
    chk("f1_c28_st", st_tr[28], 3);
    chk("f1_c28_row", row_tr[28], 0);
    chk("f1_c29_row", row_tr[29], 1);
    chk("f1_c30_row", row_tr[30], 2);
    chk("f1_c30_win", win_tr[30], 1);
    chk("f1_c28_outrow", or_tr[28], 0);
    chk("f1_c31_bias", st_tr[31], 4);
    chk("f1_c31_row", row_tr[31], 3);
    chk("f1_c31_win", win_tr[31], 0);
    chk("f1_c32_load", st_tr[32], 5);
    chk("f1_c32_outrow", or_tr[32], 1);
    chk("f1_c39_col", col_tr[39], 7);
    chk("f1_c40_shift", st_tr[40], 3);
    chk("f1_pix_c40", pix_tr[40], 32);
    chk("f1_c88_outrow", or_tr[88], 5);
    chk("f1_pix_c88", pix_tr[88], 64);
    chk("f1_c90_row", row_tr[90], 2);
    chk("f1_c91_bias", st_tr[91], 4);
    chk("f1_c91_busy", busy_tr[91], 1);
    chk("f1_c92_busy", busy_tr[92], 0);
    chk("f1_c92_idle", st_tr[92], 0);
    chk("f1_c92_outrow", or_tr[92], 5);

    // Bubble of 4 cycles at the first LOAD column 0.
    dat_bad = 0;
    @(posedge clk);
    #1 start = 1'b1;
    run_frame(32, 4, -1, -1, 1'b0, dc, np, nw, nd, ns);
    chk("bub_done_cyc", dc, 96);
    chk("bub_pixels", np, 64);
    chk("bub_load_shifts", ns, 5);
    chk("bub_c32_mask", st_tr[32], 0);
    chk("bub_c35_mask", st_tr[35], 0);
    chk("bub_c35_col", col_tr[35], 0);
    chk("bub_c36_load", st_tr[36], 5);
    chk("bub_c37_col", col_tr[37], 1);
    chk("bub_win_cycles", nw, 18);
    chk("bub_data_in", dat_bad, 0);

    // start pulsed at cycle 40 while busy.
    @(posedge clk);
    #1 start = 1'b1;
    run_frame(-1, 0, 40, -1, 1'b0, dc, np, nw, nd, ns);
    chk("stb_done_cyc", dc, 92);
    chk("stb_done_count", nd, 1);
    chk("stb_pixels", np, 64);
    chk("stb_c41_st", st_tr[41], 3);

    // Back-to-back: restart in the done cycle.
    @(posedge clk);
    #1 start = 1'b1;
    run_frame(-1, 0, -1, -1, 1'b1, dc, np, nw, nd, ns);
    chk("b2b1_done_cyc", dc, 92);
    for (int i = 0; i < 93; i++) begin
      st_sv[i]  = st_tr[i];
      col_sv[i] = col_tr[i];
      row_sv[i] = row_tr[i];
    end
    run_frame(-1, 0, -1, -1, 1'b0, dc, np, nw, nd, ns);
    chk("b2b2_done_cyc", dc, 92);
    chk("b2b2_c0_init", st_tr[0], 1);
    chk("b2b2_pixels", np, 64);
    chk("b2b2_win_cycles", nw, 18);
    diffs = 0;
    for (int i = 0; i < 93; i++) begin
      if (st_sv[i] != st_tr[i] || col_sv[i] != col_tr[i] || row_sv[i] != row_tr[i]) diffs++;
    end
    chk("b2b_trace_diffs", diffs, 0);

    // Reset mid-LOAD: outputs return to reset values before the next edge.
    @(posedge clk);
    #1 start = 1'b1;
    run_frame(-1, 0, -1, 34, 1'b0, dc, np, nw, nd, ns);
    chk("rml_pre_st", st_tr[34], 5);
    chk("rml_pre_col", col_tr[34], 2);
    #1 rst = 1'b1;
    #1;
    chk("rml_state", int'(current_state), 0);
    chk("rml_col", int'(col_index), 0);
    chk("rml_row", int'(row_index), 3);
    chk("rml_pc", int'(preload_cycle), 1);
    chk("rml_outrow", int'(out_row), 0);
    chk("rml_ready", int'(pix_if.in_ready), 0);
    chk("rml_win", int'(win_valid), 0);
    chk("rml_busy", int'(busy), 0);
    chk("rml_done", int'(done), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    ndone_r = 0;
    nbusy_r = 0;
    repeat (110) begin
      @(posedge clk);
      #1;
      if (done) ndone_r++;
      if (busy) nbusy_r++;
    end
    chk("rml_no_done", ndone_r, 0);
    chk("rml_no_busy", nbusy_r, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
